// File: rtl/vga_timing_gen_pkg.sv
// Shared raster timing constants and helpers for vga_timing_gen and its axes.
package vga_timing_pkg;

  // 640x480@60 Hz default timing (pixels / lines)
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Sync asserted levels
  localparam bit POL_ACTIVE_LOW  = 1'b0;
  localparam bit POL_ACTIVE_HIGH = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Total period of an axis from its four segments
  function automatic int calc_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_axis.sv
// One raster axis: wrap counter with registered sync/active decode.
// The first advance after clear presents count 0 (with decoded flags)
// instead of incrementing, so the axis starts cleanly at the origin.
module timing_axis #(
  parameter int W          = 10,
  parameter int TOTAL      = 800,
  parameter int SYNC_START = 656,
  parameter int SYNC_END   = 752,
  parameter int ACTIVE_END = 640,
  parameter bit POL        = 1'b0
) (
  input  logic         clk,
  input  logic         advance,
  input  logic         clear,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         sync,
  output logic         active
);

  localparam int unsigned WX = W + 1;
  localparam logic [W-1:0] LAST = W'(TOTAL - 1);
  // One extra bit so an end bound equal to 2^W is still representable
  localparam logic [W:0] SS = WX'(SYNC_START);
  localparam logic [W:0] SE = WX'(SYNC_END);
  localparam logic [W:0] AE = WX'(ACTIVE_END);

  logic         run_q, run_d;
  logic [W-1:0] count_q, count_d;
  logic         sync_q, sync_d;
  logic         active_q, active_d;
  logic [W:0]   cnt_x;

  // Next advance loads 0: either not yet running or at terminal count
  assign wrap = ~run_q | (count_q == LAST);

  // Next count and flags decoded from that next count (no extra stage)
  always_comb begin
    run_d    = run_q;
    count_d  = count_q;
    sync_d   = sync_q;
    active_d = active_q;
    cnt_x    = '0;
    if (clear) begin
      run_d    = 1'b0;
      count_d  = '0;
      sync_d   = ~POL;
      active_d = 1'b0;
    end else if (advance) begin
      run_d    = 1'b1;
      count_d  = wrap ? '0 : count_q + 1'b1;
      cnt_x    = {1'b0, count_d};
      sync_d   = (cnt_x >= SS && cnt_x < SE) ? POL : ~POL;
      active_d = (cnt_x < AE);
    end
  end

  // Axis state registers; clear acts as the synchronous reset
  always_ff @(posedge clk) begin
    run_q    <= run_d;
    count_q  <= count_d;
    sync_q   <= sync_d;
    active_q <= active_d;
  end

  assign count  = count_q;
  assign sync   = sync_q;
  assign active = active_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: two timing_axis counters plus
// the IDLE/RUN control, line/frame start pulses and frame counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int W        = 10,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit H_POL    = POL_ACTIVE_LOW,
  parameter bit V_POL    = POL_ACTIVE_LOW,
  parameter int FW       = 8
) (
  input  logic          i_Clk,
  input  logic          i_Rst_n,
  input  logic          i_En,
  output logic [W-1:0]  o_HPos,
  output logic [W-1:0]  o_VPos,
  output logic          o_HSync,
  output logic          o_VSync,
  output logic          o_Active,
  output logic          o_LineStart,
  output logic          o_FrameStart,
  output logic [FW-1:0] o_FrameCnt
);

  localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  // Parameter sanity
  if (H_ACTIVE < 1 || H_SYNC < 1 || V_ACTIVE < 1 || V_SYNC < 1) begin : g_bad_seg
    $error("vga_timing_gen: active and sync segments must be at least 1");
  end
  if (H_FP < 0 || H_BP < 0 || V_FP < 0 || V_BP < 0) begin : g_bad_porch
    $error("vga_timing_gen: porch segments must not be negative");
  end
  if (H_TOTAL > (1 << W) || V_TOTAL > (1 << W)) begin : g_bad_w
    $error("vga_timing_gen: W too narrow for H_TOTAL-1 / V_TOTAL-1");
  end

  logic h_wrap, v_wrap, h_sync, v_sync, h_act, v_act;
  logic axis_clear;

  assign axis_clear = ~i_Rst_n;

  timing_axis #(
    .W(W), .TOTAL(H_TOTAL),
    .SYNC_START(H_ACTIVE + H_FP), .SYNC_END(H_ACTIVE + H_FP + H_SYNC),
    .ACTIVE_END(H_ACTIVE), .POL(H_POL)
  ) u_h (
    .clk(i_Clk), .advance(i_En), .clear(axis_clear),
    .count(o_HPos), .wrap(h_wrap), .sync(h_sync), .active(h_act)
  );

  // Vertical axis steps only on the enabled edge that wraps the line
  timing_axis #(
    .W(W), .TOTAL(V_TOTAL),
    .SYNC_START(V_ACTIVE + V_FP), .SYNC_END(V_ACTIVE + V_FP + V_SYNC),
    .ACTIVE_END(V_ACTIVE), .POL(V_POL)
  ) u_v (
    .clk(i_Clk), .advance(i_En & h_wrap), .clear(axis_clear),
    .count(o_VPos), .wrap(v_wrap), .sync(v_sync), .active(v_act)
  );

  state_e        state_q, state_d;
  logic          line_q, line_d;
  logic          frame_q, frame_d;
  logic [FW-1:0] fcnt_q, fcnt_d;

  // Next state, pulses and frame count; pulses default low every edge
  always_comb begin
    state_d = state_q;
    line_d  = 1'b0;
    frame_d = 1'b0;
    fcnt_d  = fcnt_q;
    if (i_En) begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_RUN;
          line_d  = 1'b1;
          frame_d = 1'b1;
        end
        ST_RUN: begin
          line_d = h_wrap;
          if (h_wrap && v_wrap) begin
            frame_d = 1'b1;
            fcnt_d  = fcnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control registers with synchronous active-low reset
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state_q <= ST_IDLE;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      frame_q <= frame_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign o_HSync      = h_sync;
  assign o_VSync      = v_sync;
  assign o_Active     = h_act & v_act;
  assign o_LineStart  = line_q;
  assign o_FrameStart = frame_q;
  assign o_FrameCnt   = fcnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations driven by the same
// stimulus, compared every clock against an enabled-tick-count model.
module tb_vga_timing_gen;

  typedef struct {
    string name;
    int ha, hf, hs, hb;
    int va, vf, vs, vb;
    bit hp, vp;
    int fw;
  } cfg_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: started flag, enabled ticks since start, last edge enabled
  bit started = 1'b0;
  int n = 0;
  bit pulse = 1'b0;
  cfg_t cfg[3];

  logic [3:0] s_h, s_v, p_h, p_v;
  logic [9:0] d_h, d_v;
  logic [1:0] s_fc;
  logic [7:0] p_fc, d_fc;
  logic s_hs, s_vs, s_ac, s_ls, s_fs;
  logic p_hs, p_vs, p_ac, p_ls, p_fs;
  logic d_hs, d_vs, d_ac, d_ls, d_fs;

  vga_timing_gen #(.W(4), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1'b0), .V_POL(1'b0), .FW(2))
  u_small (.i_Clk(clk), .i_Rst_n(rst_n), .i_En(en), .o_HPos(s_h), .o_VPos(s_v),
    .o_HSync(s_hs), .o_VSync(s_vs), .o_Active(s_ac), .o_LineStart(s_ls),
    .o_FrameStart(s_fs), .o_FrameCnt(s_fc));

  vga_timing_gen #(.W(4), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1'b1), .V_POL(1'b1), .FW(8))
  u_pol (.i_Clk(clk), .i_Rst_n(rst_n), .i_En(en), .o_HPos(p_h), .o_VPos(p_v),
    .o_HSync(p_hs), .o_VSync(p_vs), .o_Active(p_ac), .o_LineStart(p_ls),
    .o_FrameStart(p_fs), .o_FrameCnt(p_fc));

  vga_timing_gen u_def (.i_Clk(clk), .i_Rst_n(rst_n), .i_En(en), .o_HPos(d_h), .o_VPos(d_v),
    .o_HSync(d_hs), .o_VSync(d_vs), .o_Active(d_ac), .o_LineStart(d_ls),
    .o_FrameStart(d_fs), .o_FrameCnt(d_fc));

  int ob_h[3], ob_v[3], ob_fc[3];
  logic ob_hs[3], ob_vs[3], ob_ac[3], ob_ls[3], ob_fs[3];

  always_comb begin
    ob_h[0] = int'(s_h);  ob_v[0] = int'(s_v);  ob_fc[0] = int'(s_fc);
    ob_h[1] = int'(p_h);  ob_v[1] = int'(p_v);  ob_fc[1] = int'(p_fc);
    ob_h[2] = int'(d_h);  ob_v[2] = int'(d_v);  ob_fc[2] = int'(d_fc);
    ob_hs[0] = s_hs; ob_vs[0] = s_vs; ob_ac[0] = s_ac; ob_ls[0] = s_ls; ob_fs[0] = s_fs;
    ob_hs[1] = p_hs; ob_vs[1] = p_vs; ob_ac[1] = p_ac; ob_ls[1] = p_ls; ob_fs[1] = p_fs;
    ob_hs[2] = d_hs; ob_vs[2] = d_vs; ob_ac[2] = d_ac; ob_ls[2] = d_ls; ob_fs[2] = d_fs;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d, expected %0d (n=%0d)", tag, obs, exp, n);
    end
  endtask

  // Expected outputs from the raster rules, applied to tick count n
  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      int ht, vt, h, v, fc, ss, vss;
      bit ehs, evs, eac, els, efs;
      ht = cfg[k].ha + cfg[k].hf + cfg[k].hs + cfg[k].hb;
      vt = cfg[k].va + cfg[k].vf + cfg[k].vs + cfg[k].vb;
      ss = cfg[k].ha + cfg[k].hf;
      vss = cfg[k].va + cfg[k].vf;
      if (!started) begin
        h = 0; v = 0; fc = 0;
        ehs = ~cfg[k].hp; evs = ~cfg[k].vp;
        eac = 0; els = 0; efs = 0;
      end else begin
        h = n % ht;
        v = (n / ht) % vt;
        fc = (n / (ht * vt)) % (1 << cfg[k].fw);
        ehs = (h >= ss && h < ss + cfg[k].hs) ? cfg[k].hp : ~cfg[k].hp;
        evs = (v >= vss && v < vss + cfg[k].vs) ? cfg[k].vp : ~cfg[k].vp;
        eac = (h < cfg[k].ha) && (v < cfg[k].va);
        els = pulse && (h == 0);
        efs = pulse && (h == 0) && (v == 0);
      end
      chk({cfg[k].name, ".hpos"},   ob_h[k], h);
      chk({cfg[k].name, ".vpos"},   ob_v[k], v);
      chk({cfg[k].name, ".hsync"},  int'(ob_hs[k]), int'(ehs));
      chk({cfg[k].name, ".vsync"},  int'(ob_vs[k]), int'(evs));
      chk({cfg[k].name, ".active"}, int'(ob_ac[k]), int'(eac));
      chk({cfg[k].name, ".lstart"}, int'(ob_ls[k]), int'(els));
      chk({cfg[k].name, ".fstart"}, int'(ob_fs[k]), int'(efs));
      chk({cfg[k].name, ".fcnt"},   ob_fc[k], fc);
    end
  endtask

  // Drive one clock, advance the model, then check 1 ns after the edge
  task automatic step(input bit e, input bit r);
    @(negedge clk);
    en = e;
    rst_n = r;
    @(posedge clk);
    if (!r) begin
      started = 0; n = 0; pulse = 0;
    end else if (e) begin
      if (!started) begin started = 1; n = 0; end
      else n++;
      pulse = 1;
    end else begin
      pulse = 0;
    end
    #1;
    check_all();
  endtask

  initial begin
    bit hit;
    cfg[0] = '{"small", 4, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0, 2};
    cfg[1] = '{"pol",   4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1, 8};
    cfg[2] = '{"def", 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 8};

    // Reset with enable high: enable ignored
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    // Released but not enabled: stays idle
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    // Continuous run: two small frames and more
    for (int i = 0; i < 100; i++) step(1'b1, 1'b1);
    // Enable pattern 1-0-0-1: hold and single-clock pulses
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1);
    end
    // Random enable
    for (int i = 0; i < 300; i++) step($urandom_range(0, 3) != 0, 1'b1);

    // Reset mid-frame at small (HPos 6, VPos 4)
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      step(1'b1, 1'b1);
      hit = started && (n % 8 == 6) && ((n / 8) % 6 == 4);
    end
    chk("reach_h6_v4", int'(hit), 1);
    step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);

    // Five-plus small frames: 2-bit frame counter wraps
    for (int i = 0; i < 260; i++) step(1'b1, 1'b1);

    // A few default-timing lines with mostly-high enable
    for (int i = 0; i < 2500; i++) step($urandom_range(0, 15) != 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised raster timing generator, the next generation of the fixed 640x480 sync counter. It produces pixel/line counters, horizontal and vertical sync with configurable polarity, an active-video flag, line/frame start pulses and a frame counter, all advancing only on a pixel-clock enable. It sits between the pixel-clock enable divider and the pixel renderer (ball/paddle drawing), and drives the VGA connector sync pins directly.

## Interface
Parameters:
- W, 10: width of position counters; must hold H_TOTAL-1 and V_TOTAL-1, elaboration error otherwise
- H_ACTIVE, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal segments in pixels
- V_ACTIVE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical segments in lines
- H_POL, 0 / V_POL, 0: sync asserted level (0 = active-low)
- FW, 8: frame counter width

Ports:
- i_Clk  in  1  system clock
- i_Rst_n  in  1  reset; synchronous, active-low
- i_En  in  1  pixel enable; counters advance only on edges where high
- o_HPos  out  W  horizontal count, 0..H_TOTAL-1
- o_VPos  out  W  vertical count, 0..V_TOTAL-1
- o_HSync  out  1  horizontal sync, level per H_POL
- o_VSync  out  1  vertical sync, level per V_POL
- o_Active  out  1  high when o_HPos < H_ACTIVE and o_VPos < V_ACTIVE
- o_LineStart  out  1  one-clock pulse when o_HPos becomes 0
- o_FrameStart  out  1  one-clock pulse when (o_HPos,o_VPos) becomes (0,0)
- o_FrameCnt  out  FW  completed-frame counter, wraps modulo 2^FW

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Zero-based counting, unlike the old 1-based counter.
- FSM: IDLE, RUN.
  - IDLE: entered on any edge with i_Rst_n low. Outputs: o_HPos=0, o_VPos=0, syncs at inactive level (~H_POL, ~V_POL), o_Active=0, pulses 0, o_FrameCnt=0.
  - IDLE -> RUN on first enabled edge with i_Rst_n high: present (0,0), o_Active=1, o_LineStart=1, o_FrameStart=1. o_FrameCnt stays 0.
  - RUN, enabled edge: o_HPos increments; at H_TOTAL-1 wraps to 0 and o_VPos increments; o_VPos at V_TOTAL-1 with o_HPos wrap returns to 0 and o_FrameCnt increments.
- Sync decode: HSync asserted when H_ACTIVE+H_FP <= o_HPos < H_ACTIVE+H_FP+H_SYNC. VSync asserted for whole lines V_ACTIVE+V_FP <= o_VPos < V_ACTIVE+V_FP+V_SYNC, changing only together with o_HPos wrap to 0.
- All outputs registered and consistent with o_HPos/o_VPos in the same clock (decode from next-count values, no extra pipeline stage).
- Pulses: set on the enabled edge that loads o_HPos=0 (and o_VPos=0 for frame), cleared on the next clock edge regardless of i_En.
- i_En low: counters, syncs, o_Active, o_FrameCnt hold; pulses clear.

## Timing
- Latency: zero cycles between counter value and its decoded flags.
- Reset mid-frame: next edge with i_Rst_n low forces IDLE values; i_En ignored during reset.
- Reset priority over i_En; IDLE->RUN requires i_En.
- o_FrameCnt wraps from 2^FW-1 to 0 with no flag.
- Segments of length 0 for FP/BP are legal; H_SYNC, V_SYNC, H_ACTIVE, V_ACTIVE must be >=1 (elaboration check).

## Structure
- Shared package vga_timing_pkg: 640x480@60 default timing constants, polarity constants, and a function computing total from four segments; the existing timing include maps onto it.
- One sub-module, timing_axis: generic wrap counter with parameters TOTAL, SYNC_START, SYNC_END, ACTIVE_END and inputs advance/clear; outputs count, wrap, sync, active. Instantiated twice: horizontal (advance=i_En) and vertical (advance=i_En & horizontal wrap).
- FSM and pulse/frame-counter logic live in vga_timing_gen.

## Test plan
- Small config H 4/1/2/1, V 3/1/1/1, W=4: after reset + 48 enabled clocks -> o_HPos cycles 0..7, o_VPos 0..5, HSync low exactly at HPos 5,6, VSync low for all of VPos 4.
- Same config: o_Active high only for HPos 0..3 with VPos 0..2 (12 clocks per frame); o_FrameStart once per 48 enabled clocks; o_FrameCnt 0,1,2.
- i_En pattern 1-0-0-1 -> counters hold during low cycles; o_LineStart width exactly 1 clock even when i_En drops right after.
- Assert i_Rst_n low at (HPos 6, VPos 4) -> next edge all outputs at IDLE values; release with i_En low for 3 clocks -> stays IDLE; first i_En -> (0,0) with both pulses.
- H_POL=1, V_POL=1 -> syncs idle low, high in sync windows; defaults (800x525) -> one frame = 420000 enabled clocks, HSync low 96 clocks per line.
- FW=2: run 5 frames -> o_FrameCnt 1,2,3,0,1.
